// File: rtl/pipeline_trace_buffer.sv
// Decode-stage trace capture: a circular buffer that is armed, triggered, fills POST_TRIG entries, then drains oldest-first.
// Optional stall filter (drops repeated PCs) is enabled by defining TRACE_FILTER_EN.
module pipeline_trace_buffer #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     trig,
    input  logic                     cap_valid,
    input  logic [XLEN-1:0]          cap_pc,
    input  logic [31:0]              cap_instr,
    input  logic [4:0]               cap_rs1,
    input  logic [4:0]               cap_rs2,
    input  logic [4:0]               cap_rd,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [XLEN-1:0]          rd_pc,
    output logic [31:0]              rd_instr,
    output logic [4:0]               rd_rs1,
    output logic [4:0]               rd_rs2,
    output logic [4:0]               rd_rd,
    output logic [31:0]              rd_cycle,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = XLEN + 32 + 15 + 32;
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_LAST = AW'(POST_TRIG - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW-1:0]   post_cnt;
    logic [AW:0]     fill_q;
    logic [AW:0]     remain;
    logic [31:0]     cycle;
    logic [EW-1:0]   mem [DEPTH];

    logic            sample_ok;
    logic            wr_en;
    logic            xfer;
    logic            post_done;
    logic [AW-1:0]   wptr_n;
    logic [AW:0]     fill_n;

`ifdef TRACE_FILTER_EN
    logic [XLEN-1:0] last_pc;
    logic            last_pc_vld;

    assign sample_ok = cap_valid && (!last_pc_vld || (cap_pc != last_pc));

    always_ff @(posedge clk) begin
        if (rst || arm) begin
            last_pc_vld <= 1'b0;
            last_pc     <= '0;
        end else if (wr_en) begin
            last_pc_vld <= 1'b1;
            last_pc     <= cap_pc;
        end
    end
`else
    assign sample_ok = cap_valid;
`endif

    // arm takes priority over everything, including a capture in the same cycle
    assign wr_en     = ((state_q == S_ARMED) || (state_q == S_POST)) && !arm && sample_ok;
    assign xfer      = rd_valid && rd_ready;
    assign post_done = (state_q == S_POST) && wr_en && (post_cnt == POST_LAST);
    assign wptr_n    = wptr + 1'b1;
    assign fill_n    = (fill_q == FULL) ? fill_q : fill_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = S_ARMED;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_ARMED: if (trig) state_d = S_POST;
                S_POST:  if (post_done) state_d = S_DONE;
                S_DONE:  if ((remain == '0) || (xfer && (remain == (AW+1)'(1)))) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_valid = (state_q == S_DONE) && (remain != '0);
        state    = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            post_cnt <= '0;
            fill_q   <= '0;
            remain   <= '0;
            cycle    <= '0;
        end else begin
            cycle <= cycle + 1'b1;
            if (arm) begin
                wptr     <= '0;
                fill_q   <= '0;
                post_cnt <= '0;
                remain   <= '0;
            end else begin
                if (wr_en) begin
                    wptr   <= wptr_n;
                    fill_q <= fill_n;
                end
                if ((state_q == S_ARMED) && trig) begin
                    post_cnt <= '0;
                end else if ((state_q == S_POST) && wr_en) begin
                    post_cnt <= post_cnt + 1'b1;
                end
                // oldest entry sits fill entries behind the write pointer after the final write
                if (post_done) begin
                    rptr   <= wptr_n - fill_n[AW-1:0];
                    remain <= fill_n;
                end else if (xfer) begin
                    rptr   <= rptr + 1'b1;
                    remain <= remain - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= {cap_pc, cap_instr, cap_rs1, cap_rs2, cap_rd, cycle};
        end
    end

    assign {rd_pc, rd_instr, rd_rs1, rd_rs2, rd_rd, rd_cycle} = mem[rptr];
    assign fill = fill_q;

endmodule
